i2c_reg_ctrl: RTL

I2C_REG_CTRL -- requirements
Module: i2c_reg_ctrl

---
 rtl/i2c_pkg.sv | 53 +++++
 rtl/i2c_reg_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-access controller.
// Holds the byte-master command encodings, the response status codes,
// the controller state and phase enums, and a helper that maps a
// controller step onto the master command it issues.
package i2c_pkg;

  // Commands understood by the I2C byte master
  localparam logic [2:0] CMD_START   = 3'b000;
  localparam logic [2:0] CMD_WR      = 3'b001;
  localparam logic [2:0] CMD_RD      = 3'b010;
  localparam logic [2:0] CMD_STOP    = 3'b011;
  localparam logic [2:0] CMD_RESTART = 3'b100;

  // Response status codes
  localparam logic [1:0] STAT_OK        = 2'b00;
  localparam logic [1:0] STAT_ADDR_NACK = 2'b01;
  localparam logic [1:0] STAT_DATA_NACK = 2'b10;
  localparam logic [1:0] STAT_TIMEOUT   = 2'b11;

  // One state per bus step, plus idle and the response cycle
  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_DEV_W,
    S_REG,
    S_WDATA,
    S_RESTART,
    S_DEV_R,
    S_READ,
    S_STOP,
    S_RESP
  } state_e;

  // Handshake phase within a step
  typedef enum logic [1:0] {
    PH_ISSUE,
    PH_WAIT_LO,
    PH_WAIT_HI
  } phase_e;

  // Master command issued by a given step; every byte step other than
  // the read is a write.
  function automatic logic [2:0] step_cmd(input state_e s);
    case (s)
      S_START:   return CMD_START;
      S_RESTART: return CMD_RESTART;
      S_READ:    return CMD_RD;
      S_STOP:    return CMD_STOP;
      default:   return CMD_WR;
    endcase
  endfunction

endpackage

// File: rtl/i2c_reg_ctrl.sv
// I2C register-access controller.
// Turns a single register read or write request into a sequence of byte
// master commands (START / WR / RD / STOP / RESTART), tracks ACKs, applies
// a per-handshake timeout, and returns one completion pulse with status.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_rw/dev/reg/wdata     1 = read; 7-bit device; register; write data
//   rsp_valid                one-cycle completion pulse
//   rsp_rdata, rsp_status    read data, status (held until next response)
//   busy                     high whenever not idle
//   m_cmd, m_din, m_wr_i2c   command, data byte and strobe to the master
//   m_ready, m_done_tick     master ready level, byte-complete pulse
//   m_ack, m_dout            sampled ACK (0 = ACK), received byte
module i2c_reg_ctrl
  import i2c_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYC = 16'hFFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_status,
  output logic       busy,
  output logic [2:0] m_cmd,
  output logic [7:0] m_din,
  output logic       m_wr_i2c,
  input  logic       m_ready,
  input  logic       m_done_tick,
  input  logic       m_ack,
  input  logic [7:0] m_dout
);

  state_e      state;
  state_e      next_state;
  phase_e      phase;
  logic [15:0] tcnt;

  // Latched request
  logic        lat_rw;
  logic [6:0]  lat_dev;
  logic [7:0]  lat_reg;
  logic [7:0]  lat_wdata;

  // Per-step and per-transaction bookkeeping
  logic        nack_r;
  logic [7:0]  rdata_pend;
  logic [1:0]  status_pend;

  logic        nack_now;
  logic        byte_step;
  logic        timeout_hit;
  logic [1:0]  next_status;
  logic [7:0]  step_din;

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  assign byte_step = state inside {S_DEV_W, S_REG, S_WDATA, S_DEV_R, S_READ};

  // A done tick arriving in the same cycle the step completes still counts
  assign nack_now    = m_done_tick ? m_ack : nack_r;
  assign timeout_hit = (tcnt == TIMEOUT_CYC - 16'd1);

  // Data byte presented with each step's command
  // NOTE: every variable assigned in an always_comb gets a default first so
  // that no path leaves it unassigned and infers a latch.
  always_comb begin
    step_din = 8'h00;
    case (state)
      S_DEV_W: step_din = {lat_dev, 1'b0};
      S_REG:   step_din = lat_reg;
      S_WDATA: step_din = lat_wdata;
      S_DEV_R: step_din = {lat_dev, 1'b1};
      S_READ:  step_din = 8'h01;  // master NACKs the single read byte
      default: step_din = 8'h00;
    endcase
  end

  // Step sequencing once the current step's handshake completes
  always_comb begin
    next_state  = S_IDLE;
    next_status = STAT_OK;
    case (state)
      S_START:   next_state = S_DEV_W;
      S_DEV_W: begin
        if (nack_now) begin
          next_state  = S_STOP;
          next_status = STAT_ADDR_NACK;
        end else begin
          next_state = S_REG;
        end
      end
      S_REG: begin
        if (nack_now) begin
          next_state  = S_STOP;
          next_status = STAT_DATA_NACK;
        end else begin
          next_state = lat_rw ? S_RESTART : S_WDATA;
        end
      end
      S_WDATA: begin
        next_state = S_STOP;
        if (nack_now) next_status = STAT_DATA_NACK;
      end
      S_RESTART: next_state = S_DEV_R;
      S_DEV_R: begin
        if (nack_now) begin
          next_state  = S_STOP;
          next_status = STAT_ADDR_NACK;
        end else begin
          next_state = S_READ;
        end
      end
      S_READ:    next_state = S_STOP;  // ack of the read byte is ignored
      S_STOP:    next_state = S_RESP;
      default:   next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      phase       <= PH_ISSUE;
      tcnt        <= 16'd0;
      lat_rw      <= 1'b0;
      lat_dev     <= 7'd0;
      lat_reg     <= 8'h00;
      lat_wdata   <= 8'h00;
      nack_r      <= 1'b0;
      rdata_pend  <= 8'h00;
      status_pend <= STAT_OK;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 8'h00;
      rsp_status  <= STAT_OK;
      m_cmd       <= CMD_START;
      m_din       <= 8'h00;
      m_wr_i2c    <= 1'b0;
    end else begin
      m_wr_i2c  <= 1'b0;
      rsp_valid <= 1'b0;

      if (byte_step && m_done_tick) begin
        nack_r <= m_ack;
        if (state == S_READ) rdata_pend <= m_dout;
      end

      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_rw      <= req_rw;
            lat_dev     <= req_dev;
            lat_reg     <= req_reg;
            lat_wdata   <= req_wdata;
            rdata_pend  <= 8'h00;
            status_pend <= STAT_OK;
            nack_r      <= 1'b0;
            state       <= S_START;
            phase       <= PH_ISSUE;
            tcnt        <= 16'd0;
          end
        end

        S_RESP: begin
          state <= S_IDLE;
          phase <= PH_ISSUE;
          tcnt  <= 16'd0;
        end

        default: begin
          case (phase)
            PH_ISSUE: begin
              if (m_ready) begin
                m_cmd    <= step_cmd(state);
                m_din    <= step_din;
                m_wr_i2c <= 1'b1;
                nack_r   <= 1'b0;
                phase    <= PH_WAIT_LO;
                tcnt     <= 16'd0;
              end
            end

            PH_WAIT_LO: begin
              if (!m_ready) begin
                phase <= PH_WAIT_HI;
                tcnt  <= 16'd0;
              end else if (timeout_hit) begin
                // A hung master cannot be trusted with STOP either
                state      <= S_RESP;
                phase      <= PH_ISSUE;
                tcnt       <= 16'd0;
                rsp_valid  <= 1'b1;
                rsp_status <= STAT_TIMEOUT;
                rsp_rdata  <= 8'h00;
              end else begin
                tcnt <= tcnt + 16'd1;
              end
            end

            PH_WAIT_HI: begin
              if (m_ready) begin
                state <= next_state;
                phase <= PH_ISSUE;
                tcnt  <= 16'd0;
                if (next_status != STAT_OK) status_pend <= next_status;
                if (next_state == S_RESP) begin
                  rsp_valid  <= 1'b1;
                  rsp_status <= status_pend;
                  rsp_rdata  <= (status_pend == STAT_OK) ? rdata_pend : 8'h00;
                end
              end else if (timeout_hit) begin
                state      <= S_RESP;
                phase      <= PH_ISSUE;
                tcnt       <= 16'd0;
                rsp_valid  <= 1'b1;
                rsp_status <= STAT_TIMEOUT;
                rsp_rdata  <= 8'h00;
              end else begin
                tcnt <= tcnt + 16'd1;
              end
            end

            default: begin
              phase <= PH_ISSUE;
              tcnt  <= 16'd0;
            end
          endcase
        end
      endcase
    end
  end

endmodule
